// File: rtl/scaler_pkg.sv
// ============================================================================
//  scaler_pkg
//  Shared constants and controller state encoding for the scaler step logic.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package scaler_pkg;

    localparam int          FRAC_BITS  = 12;
    localparam int          STEP_WIDTH = 16;
    localparam logic [15:0] SCALE_ONE  = 16'd4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } scaler_state_t;

endpackage

`default_nettype wire

// File: rtl/udiv_seq.sv
// ============================================================================
//  udiv_seq
//  Sequential restoring unsigned divider, one quotient bit per cycle, MSB first.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module udiv_seq #(
    parameter int DIVIDEND_W = 25,
    parameter int DIVISOR_W  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int RW = DIVISOR_W + 1;
    localparam int CW = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] r_quo;
    logic [RW-1:0]         r_rem;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [CW-1:0]         r_cnt;

    logic [RW:0]           w_rem_sh;
    logic [RW:0]           w_diff;
    logic                  w_ge;

    // The dividend register doubles as the quotient: its MSB shifts into the
    // remainder while the new quotient bit shifts in at the LSB.
    assign w_rem_sh = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_ge     = (w_rem_sh >= (RW+1)'(r_dvs));
    assign w_diff   = w_rem_sh - (RW+1)'(r_dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
            r_cnt <= CW'(DIVIDEND_W);
        end else if (r_cnt != '0) begin
            r_rem <= RW'(w_ge ? w_diff : w_rem_sh);
            r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // High during the final iteration; quotient is valid the following cycle.
    assign done     = (r_cnt == CW'(1));
    assign quotient = r_quo;

endmodule

`default_nettype wire

// File: rtl/scaler_step_ctrl.sv
// ============================================================================
//  scaler_step_ctrl
//  Computes the 4.12 horizontal scale step and applies it at frame boundaries.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module scaler_step_ctrl #(
    parameter int WIDTH_BITS = 13,
    parameter int FRAC_BITS  = 12,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_BITS-1:0] cfg_in_width,
    input  logic [WIDTH_BITS-1:0] cfg_out_width,
    input  logic                  cfg_wr,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    input  logic                  vs_i,
    output logic [STEP_WIDTH-1:0] scale_step,
    output logic                  step_pending,
    output logic                  step_update
);

    import scaler_pkg::*;

    localparam int                  DW         = WIDTH_BITS + FRAC_BITS;
    localparam logic [STEP_WIDTH-1:0] c_step_one = STEP_WIDTH'(1) << FRAC_BITS;

    scaler_state_t         r_state;
    logic [WIDTH_BITS-1:0] r_in_w;
    logic [WIDTH_BITS-1:0] r_out_w;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_vs_d;
    logic [STEP_WIDTH-1:0] r_step;
    logic [STEP_WIDTH-1:0] r_pend_val;
    logic                  r_pending;
    logic                  r_update;

    logic                  w_widths_ok;
    logic                  w_div_start;
    logic                  w_div_done;
    logic [DW-1:0]         w_quo;
    logic                  w_ovf;
    logic                  w_vs_rise;

    assign w_widths_ok = (r_in_w != '0) && (r_out_w != '0);
    assign w_div_start = (r_state == CHECK) && w_widths_ok;
    assign w_ovf       = |w_quo[DW-1:STEP_WIDTH];
    assign w_vs_rise   = vs_i && !r_vs_d;

    udiv_seq #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (WIDTH_BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend ({r_in_w, {FRAC_BITS{1'b0}}}),
        .divisor  (r_out_w),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_w     <= '0;
            r_out_w    <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_vs_d     <= 1'b0;
            r_step     <= c_step_one;
            r_pend_val <= c_step_one;
            r_pending  <= 1'b0;
            r_update   <= 1'b0;
        end else begin
            r_vs_d   <= vs_i;
            r_update <= 1'b0;

            // The frame edge reads the pending state from before this cycle, so a
            // result completing in DONE right now waits for the next edge.
            if (w_vs_rise && r_pending) begin
                r_step    <= r_pend_val;
                r_pending <= 1'b0;
                r_update  <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (cfg_wr) begin
                        r_in_w  <= cfg_in_width;
                        r_out_w <= cfg_out_width;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!w_widths_ok) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_ovf) begin
                        r_err <= 1'b1;
                    end else begin
                        r_pend_val <= STEP_WIDTH'(w_quo);
                        r_pending  <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_busy     = r_busy;
    assign cfg_err      = r_err;
    assign scale_step   = r_step;
    assign step_pending = r_pending;
    assign step_update  = r_update;

endmodule

`default_nettype wire
